uart_tx_periph: RTL

- Memory-mapped UART transmitter hanging off the MicroRV32Top data bus.
- Consumes CPU stores and serialises them onto a single TX line.
- Simulation benches observe program output there instead of peeking into the register file.
- Contents: a byte FIFO, a programmable baud divider and an 8N1 serialiser FSM.

---
 rtl/uart_tx_periph.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
//
// Memory-mapped 8N1 UART transmitter for the MicroRV32Top data bus. CPU stores
// to TXDATA are queued in a byte FIFO and serialised onto tx, LSB first, with a
// programmable number of clocks per bit.
//
// Register map (bus_addr[3:2]):
//   0 TXDATA (W)   wdata[7:0] is queued; store stalls while the FIFO is full.
//   1 STATUS (R)   bit0 full, bit1 empty, bit2 busy, bits[7:4] fill count (sat. 15).
//   2 DIV    (R/W) bits[15:0] clocks per bit; writing 0 stores 1.
//   3 IRQEN  (R/W) bit0 interrupt enable (only with UART_TX_IRQ_EN), else reserved.
//
// Optional feature macro: UART_TX_IRQ_EN adds the irq output and register 3.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   bus_valid  access request, held until bus_ready
//   bus_write  1 = store, 0 = load
//   bus_addr   byte offset, [3:2] select the register
//   bus_wdata  store data
//   bus_ready  one-cycle completion pulse, one cycle after acceptance
//   bus_rdata  load data, valid while bus_ready = 1
//   tx         serial output, idle high
//   irq        (UART_TX_IRQ_EN only) enable & fifo empty & serialiser idle
// -----------------------------------------------------------------------------
module uart_tx_periph #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_valid,
    input  logic        bus_write,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_AUX    = 2'd3
    } reg_sel_t;

    // FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Serialiser
    state_t        state;
    logic [7:0]    shift;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic          bit_done;
    logic [15:0]   div;

    // Bus
    reg_sel_t      sel;
    logic          req;
    logic          stall;
    logic          accept;
    logic [31:0]   rd_val;
    logic [3:0]    fill_sat;

`ifdef UART_TX_IRQ_EN
    logic          irq_en;
`endif

    // Address bits [1:0] and the upper store data bits have no function.
    logic unused_bits;
    assign unused_bits = ^{bus_wdata[31:16], bus_addr[1:0]};

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign bit_done   = (bit_cnt == 16'd0);

    // The serialiser pops when idle, or at the end of a stop bit so the next
    // start bit follows without an idle gap.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

    assign sel    = reg_sel_t'(bus_addr[3:2]);
    assign req    = bus_valid && !bus_ready;
    // A store into a full FIFO waits, unless a slot frees in this very cycle.
    assign stall  = req && bus_write && (sel == REG_TXDATA) && fifo_full && !pop;
    assign accept = req && !stall;
    assign push   = accept && bus_write && (sel == REG_TXDATA);

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rd_val   = 32'd0;
        fill_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        case (sel)
            REG_STATUS: rd_val = {24'd0, fill_sat, 1'b0, (state != IDLE), fifo_empty, fifo_full};
            REG_DIV:    rd_val = {16'd0, div};
`ifdef UART_TX_IRQ_EN
            REG_AUX:    rd_val = {31'd0, irq_en};
`endif
            default:    rd_val = 32'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; pointers and count
    // alone decide which entries are valid, so the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus registers and handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_ready <= 1'b0;
            bus_rdata <= 32'd0;
            div       <= DEFAULT_DIV;
`ifdef UART_TX_IRQ_EN
            irq_en    <= 1'b0;
`endif
        end else begin
            bus_ready <= accept;
            bus_rdata <= (accept && !bus_write) ? rd_val : 32'd0;
            if (accept && bus_write) begin
                case (sel)
                    REG_DIV: div <= (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];
`ifdef UART_TX_IRQ_EN
                    REG_AUX: irq_en <= bus_wdata[0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Serialiser FSM. bit_cnt counts DIV-1 down to 0 for every bit; it is
    // reloaded from div at each bit boundary, so a DIV write mid-frame only
    // changes the length of the following bits.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so each one samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= 8'd0;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_mem[rd_ptr];
                        bit_cnt <= div - 16'd1;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_cnt <= div - 16'd1;
                        bit_idx <= 3'd0;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= div - 16'd1;
                        if (pop) begin
                            shift <= fifo_mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && fifo_empty && (state == IDLE);
        end
    end
`endif

endmodule
